// File: rtl/sisc_seq_pkg.sv
// Shared types and constants for the SISC multi-cycle sequencer.
// Contents: state and opcode codes, alu_op codes, the control-strobe bundle,
// and the branch-condition helper.
package sisc_seq_pkg;

  localparam int unsigned STATE_W  = 3;
  localparam int unsigned OP_W     = 4;
  localparam int unsigned MM_W     = 4;
  localparam int unsigned STAT_W   = 4;
  localparam int unsigned ALU_OP_W = 2;

  typedef logic [STATE_W-1:0]  state_t;
  typedef logic [OP_W-1:0]     opcode_t;
  typedef logic [ALU_OP_W-1:0] alu_op_t;

  // Sequencer states (binary encoded)
  localparam state_t RST    = 3'd0;
  localparam state_t FETCH  = 3'd1;
  localparam state_t DECODE = 3'd2;
  localparam state_t EXEC   = 3'd3;
  localparam state_t MEM    = 3'd4;
  localparam state_t WB     = 3'd5;
  localparam state_t HALT   = 3'd6;

  // Opcodes in ir[31:28]; 6..E are reserved and behave as NOP
  localparam opcode_t OP_NOP = 4'h0;
  localparam opcode_t OP_ALU = 4'h1;
  localparam opcode_t OP_LOD = 4'h2;
  localparam opcode_t OP_STR = 4'h3;
  localparam opcode_t OP_BRA = 4'h4;
  localparam opcode_t OP_BRR = 4'h5;
  localparam opcode_t OP_HLT = 4'hF;

  // ALU operation select
  localparam alu_op_t ALU_IDLE  = 2'b00;
  localparam alu_op_t ALU_ARITH = 2'b01;
  localparam alu_op_t ALU_ADDR  = 2'b10;

  // Per-cycle control strobes driven into the datapath and memory port
  typedef struct packed {
    logic    mem_req;
    logic    mem_we;
    logic    ir_load;
    logic    pc_rst;
    logic    pc_write;
    logic    pc_sel;
    logic    br_sel;
    logic    rf_we;
    logic    wb_sel;
    logic    rd_sel;
    alu_op_t alu_op;
    logic    halted;
  } ctrl_t;

  // A zero mask means "branch always"; otherwise any selected flag set takes it
  function automatic logic branch_taken(input logic [MM_W-1:0]   mm,
                                        input logic [STAT_W-1:0] stat);
    return ((stat & mm) != '0) || (mm == '0);
  endfunction

  // Opcodes that continue past DECODE into an EXEC cycle
  function automatic logic needs_exec(input opcode_t op);
    return (op == OP_ALU) || (op == OP_LOD) || (op == OP_STR) ||
           (op == OP_BRA) || (op == OP_BRR);
  endfunction

endpackage

// File: rtl/sisc_seq_if.sv
// Instruction/data memory request handshake.
//   mem_req : request, held until mem_rdy is seen
//   mem_we  : 1 = store, meaningful only with mem_req
//   mem_rdy : memory completes the current request this cycle
interface sisc_seq_if;
  logic mem_req;
  logic mem_we;
  logic mem_rdy;

  modport master (output mem_req, output mem_we, input  mem_rdy);
  modport slave  (input  mem_req, input  mem_we, output mem_rdy);
endinterface

// File: rtl/sisc_seq_mem_wdog.sv
// Memory wait watchdog: counts consecutive stalled request cycles.
//   clk, rst_f : clock, async active-low reset
//   clr        : return count to zero
//   inc        : a request is stalled this cycle
//   expired_c  : this stalled cycle is the MEM_TIMEOUT-th in a row
module sisc_seq_mem_wdog #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 5
) (
  input  logic clk,
  input  logic rst_f,
  input  logic clr,
  input  logic inc,
  output logic expired_c
);

  logic [CNT_W-1:0] cnt_q;

  // Stall counter
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Fires on the stalled cycle that brings the count to MEM_TIMEOUT, so a
  // mem_rdy on that same cycle (inc low) still completes normally.
  assign expired_c = inc && (cnt_q == CNT_W'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/sisc_seq.sv
// Multi-cycle SISC instruction sequencer.
//   clk, rst_f     : clock, async active-low reset
//   opcode, mm     : ir[31:28], ir[27:24] (valid from DECODE onward)
//   stat           : status-register flags
//   mem            : memory handshake (master side)
//   ir_load        : load IR from memory read data
//   pc_rst/pc_write/pc_sel/br_sel : program-counter controls
//   rf_we/wb_sel/rd_sel           : register-file write-back controls
//   alu_op         : 00 idle, 01 arith + flags, 10 address calc
//   halted/bus_err : stopped on HLT or memory timeout
module sisc_seq
  import sisc_seq_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 5
) (
  input  logic                 clk,
  input  logic                 rst_f,
  input  opcode_t              opcode,
  input  logic [MM_W-1:0]      mm,
  input  logic [STAT_W-1:0]    stat,
  sisc_seq_if.master           mem,
  output logic                 ir_load,
  output logic                 pc_rst,
  output logic                 pc_write,
  output logic                 pc_sel,
  output logic                 br_sel,
  output logic                 rf_we,
  output logic                 wb_sel,
  output logic                 rd_sel,
  output alu_op_t              alu_op,
  output logic                 halted,
  output logic                 bus_err
);

  state_t state_q;
  state_t state_d;
  ctrl_t  ctrl;
  logic   stall_c;
  logic   expired_c;
  logic   err_q;

  // A request cycle without mem_rdy is a stall; anything else restarts the count
  assign stall_c = ctrl.mem_req && !mem.mem_rdy;

  sisc_seq_mem_wdog #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .CNT_W      (CNT_W)
  ) u_mem_wdog (
    .clk      (clk),
    .rst_f    (rst_f),
    .clr      (!stall_c),
    .inc      (stall_c),
    .expired_c(expired_c)
  );

  // State register
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state_q <= RST;
    end else begin
      state_q <= state_d;
    end
  end

  // Sticky bus-error flag, cleared only by reset
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      err_q <= 1'b0;
    end else if (expired_c) begin
      err_q <= 1'b1;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      RST: state_d = FETCH;
      FETCH: begin
        if (mem.mem_rdy)    state_d = DECODE;
        else if (expired_c) state_d = HALT;
      end
      DECODE: begin
        if (opcode == OP_HLT)       state_d = HALT;
        else if (needs_exec(opcode)) state_d = EXEC;
        else                         state_d = FETCH;
      end
      EXEC: begin
        if (opcode == OP_ALU)                            state_d = WB;
        else if ((opcode == OP_LOD) || (opcode == OP_STR)) state_d = MEM;
        else                                               state_d = FETCH;
      end
      MEM: begin
        if (mem.mem_rdy)    state_d = (opcode == OP_LOD) ? WB : FETCH;
        else if (expired_c) state_d = HALT;
      end
      WB:      state_d = FETCH;
      HALT:    state_d = HALT;
      default: state_d = RST;
    endcase
  end

  // Output decode
  always_comb begin
    ctrl = '0;
    case (state_q)
      RST: ctrl.pc_rst = 1'b1;
      FETCH: begin
        ctrl.mem_req = 1'b1;
        if (mem.mem_rdy) begin
          ctrl.ir_load  = 1'b1;
          ctrl.pc_write = 1'b1;
        end
      end
      EXEC: begin
        case (opcode)
          OP_ALU:         ctrl.alu_op = ALU_ARITH;
          OP_LOD, OP_STR: ctrl.alu_op = ALU_ADDR;
          OP_BRA, OP_BRR: begin
            if (branch_taken(mm, stat)) begin
              ctrl.pc_write = 1'b1;
              ctrl.pc_sel   = 1'b1;
              ctrl.br_sel   = (opcode == OP_BRR);
            end
          end
          default: ;
        endcase
      end
      MEM: begin
        ctrl.mem_req = 1'b1;
        ctrl.mem_we  = (opcode == OP_STR);
        ctrl.alu_op  = ALU_ADDR;
      end
      WB: begin
        ctrl.rf_we = 1'b1;
        if (opcode == OP_LOD) begin
          ctrl.rd_sel = 1'b1;
          ctrl.alu_op = ALU_ADDR;
        end else begin
          ctrl.wb_sel = 1'b1;
        end
      end
      HALT:    ctrl.halted = 1'b1;
      default: ;
    endcase
  end

  assign mem.mem_req = ctrl.mem_req;
  assign mem.mem_we  = ctrl.mem_we;
  assign ir_load     = ctrl.ir_load;
  assign pc_rst      = ctrl.pc_rst;
  assign pc_write    = ctrl.pc_write;
  assign pc_sel      = ctrl.pc_sel;
  assign br_sel      = ctrl.br_sel;
  assign rf_we       = ctrl.rf_we;
  assign wb_sel      = ctrl.wb_sel;
  assign rd_sel      = ctrl.rd_sel;
  assign alu_op      = ctrl.alu_op;
  assign halted      = ctrl.halted;
  assign bus_err     = err_q;

endmodule

// File: tb/tb_sisc_seq.sv
// Bench for sisc_seq: each instruction is expanded into an expected per-cycle
// trace of memory responses and control outputs, then replayed and compared.
module tb_sisc_seq;
  import sisc_seq_pkg::*;

  localparam int unsigned TO = 16;

  logic       clk = 1'b0;
  logic       rst_f;
  logic [3:0] opcode, mm, stat;
  logic       ir_load, pc_rst, pc_write, pc_sel, br_sel, rf_we, wb_sel, rd_sel;
  logic [1:0] alu_op;
  logic       halted, bus_err;

  sisc_seq_if mem_if();

  sisc_seq #(.MEM_TIMEOUT(TO), .CNT_W(5)) dut (
    .clk     (clk),
    .rst_f   (rst_f),
    .opcode  (opcode),
    .mm      (mm),
    .stat    (stat),
    .mem     (mem_if.master),
    .ir_load (ir_load),
    .pc_rst  (pc_rst),
    .pc_write(pc_write),
    .pc_sel  (pc_sel),
    .br_sel  (br_sel),
    .rf_we   (rf_we),
    .wb_sel  (wb_sel),
    .rd_sel  (rd_sel),
    .alu_op  (alu_op),
    .halted  (halted),
    .bus_err (bus_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       req, we, ir_load, pc_rst, pc_write, pc_sel, br_sel;
    logic       rf_we, wb_sel, rd_sel;
    logic [1:0] alu_op;
    logic       halted, bus_err;
  } obs_t;

  typedef struct packed {
    logic       rdy_x;   // memory response is don't-care: drive random
    logic       rdy;
    logic [3:0] op, mm, st;
    obs_t       exp;
  } step_t;

  step_t      trace[$];
  int         vectors     = 0;
  int         miscompares = 0;
  logic [3:0] cur_stat = 4'h0;
  logic [3:0] cur_op   = 4'h0;
  logic [3:0] cur_mm   = 4'h0;

  function automatic obs_t sample();
    obs_t o;
    o.req = mem_if.mem_req; o.we = mem_if.mem_we; o.ir_load = ir_load;
    o.pc_rst = pc_rst; o.pc_write = pc_write; o.pc_sel = pc_sel;
    o.br_sel = br_sel; o.rf_we = rf_we; o.wb_sel = wb_sel; o.rd_sel = rd_sel;
    o.alu_op = alu_op; o.halted = halted; o.bus_err = bus_err;
    return o;
  endfunction

  task automatic push(input obs_t e, input logic rx, input logic r,
                      input logic [3:0] op, input logic [3:0] m, input logic [3:0] st);
    step_t s;
    s.rdy_x = rx; s.rdy = r; s.op = op; s.mm = m; s.st = st; s.exp = e;
    trace.push_back(s);
  endtask

  task automatic push_halt(input logic err, input int n);
    obs_t e;
    e = '0; e.halted = 1'b1; e.bus_err = err;
    for (int i = 0; i < n; i++) push(e, 1'b1, 1'b0, cur_op, cur_mm, cur_stat);
  endtask

  // Reference model: expand one instruction into its expected cycle trace.
  // wf/wm = memory wait cycles before rdy in fetch / data access (>= TO: never).
  task automatic add_instr(input logic [3:0] op, input logic [3:0] m, input int wf, input int wm);
    obs_t e;
    int   nw;
    logic taken;
    nw = (wf >= int'(TO)) ? int'(TO) : wf;
    for (int i = 0; i < nw; i++) begin
      e = '0; e.req = 1'b1;
      push(e, 1'b0, 1'b0, 4'($urandom), 4'($urandom), cur_stat);
    end
    if (wf >= int'(TO)) begin push_halt(1'b1, 3); return; end
    e = '0; e.req = 1'b1; e.ir_load = 1'b1; e.pc_write = 1'b1;
    push(e, 1'b0, 1'b1, 4'($urandom), 4'($urandom), cur_stat);
    cur_op = op; cur_mm = m;
    e = '0;
    push(e, 1'b1, 1'b0, op, m, cur_stat);               // decode
    if (op == OP_HLT) begin push_halt(1'b0, 4); return; end
    if (!(op inside {OP_ALU, OP_LOD, OP_STR, OP_BRA, OP_BRR})) return;
    case (op)
      OP_ALU: begin
        e = '0; e.alu_op = 2'b01;
        push(e, 1'b1, 1'b0, op, m, cur_stat);
        cur_stat = 4'($urandom);                        // flags updated by this ALU op
        e = '0; e.rf_we = 1'b1; e.wb_sel = 1'b1;
        push(e, 1'b1, 1'b0, op, m, cur_stat);
      end
      OP_BRA, OP_BRR: begin
        taken = ((cur_stat & m) != 4'h0) || (m == 4'h0);
        e = '0; e.pc_write = taken; e.pc_sel = taken; e.br_sel = taken && (op == OP_BRR);
        push(e, 1'b1, 1'b0, op, m, cur_stat);
      end
      default: begin                                    // LOD / STR
        e = '0; e.alu_op = 2'b10;
        push(e, 1'b1, 1'b0, op, m, cur_stat);
        nw = (wm >= int'(TO)) ? int'(TO) : wm;
        e = '0; e.req = 1'b1; e.we = (op == OP_STR); e.alu_op = 2'b10;
        for (int i = 0; i < nw; i++) push(e, 1'b0, 1'b0, op, m, cur_stat);
        if (wm >= int'(TO)) begin push_halt(1'b1, 3); return; end
        push(e, 1'b0, 1'b1, op, m, cur_stat);
        if (op == OP_LOD) begin
          e = '0; e.rf_we = 1'b1; e.rd_sel = 1'b1; e.alu_op = 2'b10;
          push(e, 1'b1, 1'b0, op, m, cur_stat);
        end
      end
    endcase
  endtask

  // Replay up to max queued cycles, comparing every cycle
  task automatic run_trace(input string name, input int max);
    step_t s;
    obs_t  o;
    int    idx;
    idx = 0;
    while (trace.size() > 0 && idx < max) begin
      s = trace.pop_front();
      @(posedge clk);
      #1;
      mem_if.mem_rdy = s.rdy_x ? 1'($urandom) : s.rdy;
      opcode = s.op; mm = s.mm; stat = s.st;
      @(negedge clk);
      o = sample();
      vectors++;
      if (o !== s.exp) begin
        miscompares++;
        $display("FAIL %s cycle %0d: got %b expected %b", name, idx, o, s.exp);
      end
      idx++;
    end
  endtask

  task automatic check_reset_outputs(input string name);
    obs_t o, e;
    e = '0; e.pc_rst = 1'b1;
    o = sample();
    vectors++;
    if (o !== e) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b", name, o, e);
    end
  endtask

  // Assert reset, check the reset outputs, release, check the pc_rst cycle
  task automatic do_reset();
    @(negedge clk);
    rst_f = 1'b0;
    mem_if.mem_rdy = 1'b1;
    #1 check_reset_outputs("reset_async");
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset_held");
    @(posedge clk);
    #1 rst_f = 1'b1;
    @(negedge clk);
    check_reset_outputs("reset_release");
    trace.delete();
  endtask

  task automatic test_reset();
    do_reset();
    add_instr(OP_NOP, 4'h0, 0, 0);
    run_trace("reset_first_fetch", 1000);
  endtask

  task automatic test_alu();
    add_instr(OP_ALU, 4'h3, 0, 0);
    add_instr(OP_NOP, 4'h0, 0, 0);
    run_trace("alu", 1000);
  endtask

  task automatic test_lod_str();
    add_instr(OP_LOD, 4'h0, 0, 3);
    add_instr(OP_STR, 4'h0, 0, 0);
    add_instr(OP_STR, 4'h7, 1, 2);
    add_instr(OP_LOD, 4'h1, 2, 0);
    run_trace("lod_str", 1000);
  endtask

  task automatic test_branch();
    cur_stat = 4'b0100;
    add_instr(OP_BRR, 4'b0100, 0, 0);                   // taken, relative
    add_instr(OP_BRR, 4'b0010, 0, 0);                   // not taken
    add_instr(OP_BRA, 4'b0000, 0, 0);                   // mm=0 always taken
    add_instr(OP_BRA, 4'b1100, 0, 0);                   // taken, absolute
    add_instr(OP_BRA, 4'b1011, 1, 0);                   // not taken
    run_trace("branch", 1000);
  endtask

  task automatic test_random();
    logic [3:0] op, m;
    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 14));
      m  = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
      add_instr(op, m, $urandom_range(0, 4), $urandom_range(0, 4));
    end
    run_trace("random", 100000);
  endtask

  task automatic test_timeout();
    do_reset();
    add_instr(OP_NOP, 4'h0, TO - 1, 0);                 // rdy on the last allowed cycle
    add_instr(OP_ALU, 4'h0, TO, 0);                     // fetch never completes
    run_trace("timeout_fetch", 1000);
    do_reset();
    add_instr(OP_STR, 4'h0, 0, TO - 1);
    add_instr(OP_LOD, 4'h0, 0, TO);                     // data access never completes
    run_trace("timeout_mem", 1000);
  endtask

  task automatic test_hlt();
    do_reset();
    add_instr(OP_ALU, 4'h0, 0, 0);
    add_instr(OP_HLT, 4'h0, 1, 0);
    run_trace("hlt", 1000);
  endtask

  task automatic test_reset_mid_mem();
    do_reset();
    add_instr(OP_LOD, 4'h0, 0, 10);
    run_trace("mid_mem_pre", 6);                        // fetch, decode, exec, 3 waiting MEM cycles
    #2 rst_f = 1'b0;
    #1 check_reset_outputs("reset_mid_mem");
    trace.delete();
    do_reset();
    add_instr(OP_STR, 4'h0, 0, 1);
    run_trace("after_mid_mem", 1000);
  endtask

  initial begin
    rst_f = 1'b0;
    mem_if.mem_rdy = 1'b0;
    opcode = 4'h0; mm = 4'h0; stat = 4'h0;
    repeat (2) @(posedge clk);
    test_reset();
    test_alu();
    test_lod_str();
    test_branch();
    test_random();
    test_timeout();
    test_hlt();
    test_reset_mid_mem();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
